regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; next generation of the pipeline's 2-read/1-write register file.
- Sits between decode (reads), issue (scoreboard marking) and writeback (writes).
- Adds configurable port counts and width, hardwired-zero r0, and per-port write-through forwarding.
- Adds a pending-write scoreboard and a post-reset clear sequencer so that architectural state is zero after reset.

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero r0, write-through forwarding,
// a pending-write scoreboard and a post-reset clear sequencer.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [1:DEPTH-1];
  logic [DATA_W-1:0]   mem_d [1:DEPTH-1];
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [NUM_WR-1:0]   wr_ok;
  logic                iss_ok;

  // Writes and issues take effect only in RUN and never for index 0.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = (state_q == ST_RUN) && wr_en[j] &&
                 (wr_addr[j*ADDR_W +: ADDR_W] != '0);
    end
    iss_ok = (state_q == ST_RUN) && iss_valid && (iss_addr != '0);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q != '0) begin
          mem_d[ptr_q] = '0;
        end
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j]) begin
            mem_d[wr_addr[j*ADDR_W +: ADDR_W]]  = wr_data[j*DATA_W +: DATA_W];
            busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
          end
        end
        // A new producer supersedes a same-cycle completion.
        if (iss_ok) begin
          busy_d[iss_addr] = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (rst) begin
      state_d = ST_CLEAR;
      ptr_d   = ADDR_W'(1);
      busy_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    mem_q   <= mem_d;
    busy_q  <= busy_d;
  end

  assign ready = (state_q == ST_RUN);

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a   = rd_addr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
      if (ready && (a != '0)) begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[a];
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
            rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
            hit = 1'b1;
          end
        end
        rd_busy[i] = busy_q[a] & (~hit | (iss_ok && (iss_addr == a)));
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents, pending bits, clear cycles remaining.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy[DEPTH];
  int            clr_left;

  function automatic exp_t expect_now();
    exp_t e;
    e.rdy = (clr_left == 0);
    e.d   = '0;
    e.b   = '0;
    for (int i = 0; i < NR; i++) begin
      int a;
      bit hit;
      a   = int'(rd_addr[i*AW +: AW]);
      hit = 0;
      if (e.rdy && a != 0) begin
        e.d[i*DW +: DW] = m_mem[a];
        for (int j = 0; j < NW; j++)
          if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
            e.d[i*DW +: DW] = wr_data[j*DW +: DW];
            hit = 1;
          end
        e.b[i] = m_busy[a] && (!hit || (iss_valid && int'(iss_addr) == a));
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      clr_left = DEPTH - 1;
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[k]  = '0;
        m_busy[k] = 0;
      end
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      for (int j = 0; j < NW; j++) begin
        int a;
        a = int'(wr_addr[j*AW +: AW]);
        if (wr_en[j] && a != 0) begin
          m_mem[a]  = wr_data[j*DW +: DW];
          m_busy[a] = 0;
        end
      end
      if (iss_valid && iss_addr != '0) m_busy[iss_addr] = 1;
    end
  endtask

  task automatic step();
    q.push_back(expect_now());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NR; i++)
      rd_addr[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1));
    for (int j = 0; j < NW; j++) begin
      wr_en[j]            = 1'($urandom_range(0, 1));
      wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1));
      wr_data[j*DW +: DW] = $urandom;
    end
    iss_valid = 1'($urandom_range(0, 2) == 0);
    iss_addr  = AW'($urandom_range(0, 7));
  endtask

  task automatic rd_pair(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (ready !== e.rdy) begin
        bad++;
        $display("FAIL ready: got %b want %b at %0t", ready, e.rdy, $time);
      end
      for (int i = 0; i < NR; i++) begin
        total++;
        if (rd_data[i*DW +: DW] !== e.d[i*DW +: DW]) begin
          bad++;
          $display("FAIL rd_data[%0d]: got %h want %h at %0t", i, rd_data[i*DW +: DW], e.d[i*DW +: DW], $time);
        end
        total++;
        if (rd_busy[i] !== e.b[i]) begin
          bad++;
          $display("FAIL rd_busy[%0d]: got %b want %b at %0t", i, rd_busy[i], e.b[i], $time);
        end
      end
    end
  end

  task automatic sweep_reads();
    idle_inputs();
    for (int k = 0; k < DEPTH; k += 2) begin
      rd_pair(k, k + 1);
      step();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge();

    // Single-cycle reset pulse, then a full clear with ignored writes/issues.
    step();
    rst = 1'b0;
    repeat (DEPTH - 1) begin rand_inputs(); step(); end
    sweep_reads();

    // Forwarding.
    idle_inputs();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'hDEADBEEF;
    rd_pair(5, 6); step();
    wr_en = '0; step();

    // Write collision on index 7.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_pair(7, 7); step();
    wr_en = '0; step();

    // r0 is hardwired zero.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFF_FFFF};
    iss_valid = 1'b1; iss_addr = 5'd0;
    rd_pair(0, 0); step();
    idle_inputs(); rd_pair(0, 0); step();

    // Scoreboard on index 9.
    iss_valid = 1'b1; iss_addr = 5'd9; rd_pair(9, 8); step();
    iss_valid = 1'b0; step();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: DW] = 32'h42; step();
    wr_en = '0; iss_valid = 1'b1; step();
    wr_en = 2'b10; wr_addr[AW +: AW] = 5'd9; wr_data[DW +: DW] = 32'h43; step();
    idle_inputs(); rd_pair(9, 9); step();

    // Reset in the middle of a clear, at pointer 15.
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (14) begin rand_inputs(); step(); end
    rst = 1'b1; rand_inputs(); step();
    rst = 1'b0;
    repeat (DEPTH - 1) begin rand_inputs(); step(); end
    sweep_reads();

    // Random traffic in RUN with rare resets.
    repeat (600) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    repeat (DEPTH) begin rand_inputs(); step(); end
    sweep_reads();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
